// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - chunked ripple-carry add/sub pipeline with valid/ready handshake

module pipelined_ripple_adder #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  C_in,
    input  logic                  sub,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] Sum,
    output logic                  C_out,
    output logic                  ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int STAGES_SAFE = (STAGES < 1) ? 1 : STAGES;
    localparam int CHUNK       = DATA_WIDTH / STAGES_SAFE;

    if (STAGES < 1 || STAGES > DATA_WIDTH || (DATA_WIDTH % STAGES_SAFE) != 0) begin : g_param_check
        $error("pipelined_ripple_adder: STAGES must be in 1..DATA_WIDTH and divide DATA_WIDTH");
    end

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & rst_n;

    // Index k of these arrays is the input side of stage k; index 0 is fed from the ports.
    logic [STAGES:0]       v_w;
    logic [STAGES:0]       c_w;
    logic [DATA_WIDTH-1:0] sum_w [STAGES+1];
    logic [DATA_WIDTH-1:0] a_w   [STAGES];
    logic [DATA_WIDTH-1:0] b_w   [STAGES];

    assign v_w[0]   = in_valid & in_ready;
    assign c_w[0]   = sub | C_in;
    assign sum_w[0] = '0;
    assign a_w[0]   = A;
    assign b_w[0]   = sub ? ~B : B;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;

        logic [CHUNK-1:0]      s_chunk;
        logic                  c_chunk;
        logic [DATA_WIDTH-1:0] sum_next;
        logic                  v_q;
        logic                  c_q;
        logic [DATA_WIDTH-1:0] sum_q;

        always_comb begin
            c_chunk = c_w[k];
            s_chunk = '0;
            for (int i = 0; i < CHUNK; i++) begin
                s_chunk[i] = a_w[k][LO+i] ^ b_w[k][LO+i] ^ c_chunk;
                c_chunk    = (a_w[k][LO+i] & b_w[k][LO+i]) |
                             (c_chunk & (a_w[k][LO+i] ^ b_w[k][LO+i]));
            end
        end

        always_comb begin
            sum_next              = sum_w[k];
            sum_next[LO +: CHUNK] = s_chunk;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q   <= v_w[k];
                c_q   <= c_chunk;
                sum_q <= sum_next;
            end
        end

        assign v_w[k+1]   = v_q;
        assign c_w[k+1]   = c_q;
        assign sum_w[k+1] = sum_q;

        if (k < STAGES - 1) begin : g_carry_operands
            logic [DATA_WIDTH-1:0] a_q;
            logic [DATA_WIDTH-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_w[k];
                    b_q <= b_w[k];
                end
            end

            assign a_w[k+1] = a_q;
            assign b_w[k+1] = b_q;
        end else begin : g_msb
            logic ovf_q;

            // Carry into the MSB equals a^b^sum at that bit, so overflow needs no extra chain tap.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= a_w[k][DATA_WIDTH-1] ^ b_w[k][DATA_WIDTH-1] ^
                             s_chunk[CHUNK-1] ^ c_chunk;
                end
            end

            assign ovf = ovf_q;
        end
    end

    assign Sum       = sum_w[STAGES];
    assign C_out     = c_w[STAGES];
    assign out_valid = v_w[STAGES];

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb/tb_pipelined_ripple_adder.sv - directed and scoreboarded bench for pipelined_ripple_adder

module tb_pipelined_ripple_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    // Returns {ovf, cout, sum[31:0]} for a w-bit operation.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [32:0] mask, aa, bb, full;
        logic [31:0] s;
        logic        co, ov;
        mask = (33'd1 << w) - 33'd1;
        aa   = {1'b0, a} & mask;
        bb   = {1'b0, (sub ? ~b : b)} & mask;
        full = aa + bb + {32'd0, (sub ? 1'b1 : cin)};
        s    = full[31:0] & mask[31:0];
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, co, s};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- main DUT: DATA_WIDTH=8, STAGES=4 ----------------
    logic       rst_n;
    logic [7:0] m_a, m_b, m_sum;
    logic       m_cin, m_sub, m_iv, m_or, m_ir, m_cout, m_ovf, m_ov;
    logic [33:0] m_q[$];

    pipelined_ripple_adder #(.DATA_WIDTH(8), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (m_a),
        .B         (m_b),
        .C_in      (m_cin),
        .sub       (m_sub),
        .in_valid  (m_iv),
        .in_ready  (m_ir),
        .Sum       (m_sum),
        .C_out     (m_cout),
        .ovf       (m_ovf),
        .out_valid (m_ov),
        .out_ready (m_or)
    );

    task automatic m_step(input logic iv, input logic orr, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub);
        logic [33:0] e;
        @(negedge clk);
        m_iv  = iv;
        m_or  = orr;
        m_a   = a;
        m_b   = b;
        m_cin = cin;
        m_sub = sub;
        #1;
        if (m_ov && m_or) begin
            if (m_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_spurious: got result 0x%0h with nothing pending, expected no result", m_sum);
            end else begin
                e = m_q.pop_front();
                chk("main_result", 64'({m_ovf, m_cout, m_sum}), 64'({e[33], e[32], e[7:0]}));
            end
        end
        if (m_iv && m_ir) m_q.push_back(model(8, {24'd0, a}, {24'd0, b}, cin, sub));
    endtask

    task automatic m_drain();
        for (int n = 0; n < 50 && m_q.size() > 0; n++) m_step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("main_drain_empty", 64'(m_q.size()), 64'd0);
    endtask

    // ---------------- parameter sweep instances ----------------
    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int W = (g <= 1) ? 8 : (g == 2) ? 16 : 32;
        localparam int S = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 2 : 4;

        logic         s_rst, s_cin, s_sub, s_iv, s_or, s_ir, s_cout, s_ovf, s_ov;
        logic         done = 1'b0;
        logic [W-1:0] s_a, s_b, s_sum;
        logic [33:0]  q[$];

        pipelined_ripple_adder #(.DATA_WIDTH(W), .STAGES(S)) u_dut (
            .clk       (clk),
            .rst_n     (s_rst),
            .A         (s_a),
            .B         (s_b),
            .C_in      (s_cin),
            .sub       (s_sub),
            .in_valid  (s_iv),
            .in_ready  (s_ir),
            .Sum       (s_sum),
            .C_out     (s_cout),
            .ovf       (s_ovf),
            .out_valid (s_ov),
            .out_ready (s_or)
        );

        task automatic s_step(input logic iv, input logic orr);
            logic [33:0] e;
            @(negedge clk);
            s_iv  = iv;
            s_or  = orr;
            s_a   = W'($urandom);
            s_b   = W'($urandom);
            s_cin = 1'($urandom);
            s_sub = 1'($urandom);
            #1;
            if (s_ov && s_or) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sweep_w%0d_s%0d_spurious: got result 0x%0h, expected none", W, S, s_sum);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("sweep_w%0d_s%0d_result", W, S),
                        64'({s_ovf, s_cout, 32'(s_sum)}), 64'({e[33], e[32], e[31:0]}));
                end
            end
            if (s_iv && s_ir) q.push_back(model(W, 32'(s_a), 32'(s_b), s_cin, s_sub));
        endtask

        initial begin
            int lat;
            s_rst = 1'b0;
            s_iv  = 1'b0;
            s_or  = 1'b1;
            s_a   = '0;
            s_b   = '0;
            s_cin = 1'b0;
            s_sub = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            s_rst = 1'b1;
            s_step(1'b1, 1'b1);
            lat = 0;
            for (int n = 0; n < 40; n++) begin
                s_step(1'b0, 1'b1);
                lat++;
                if (s_ov) break;
            end
            chk($sformatf("sweep_w%0d_s%0d_latency", W, S), 64'(lat), 64'(S));
            for (int n = 0; n < 300; n++) s_step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            for (int n = 0; n < 100 && q.size() > 0; n++) s_step(1'b0, 1'b1);
            chk($sformatf("sweep_w%0d_s%0d_drain", W, S), 64'(q.size()), 64'd0);
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    vec_t vecs[10];

    initial begin
        int lat;
        logic [3:0] all_done;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h0F, 8'hF1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[8] = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

        rst_n = 1'b0;
        m_iv  = 1'b0;
        m_or  = 1'b1;
        m_a   = 8'h00;
        m_b   = 8'h00;
        m_cin = 1'b0;
        m_sub = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_out_valid", 64'(m_ov), 64'd0);
        chk("reset_sum", 64'(m_sum), 64'd0);
        chk("reset_cout", 64'(m_cout), 64'd0);
        chk("reset_ovf", 64'(m_ovf), 64'd0);
        chk("reset_in_ready", 64'(m_ir), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 64'(m_ir), 64'd1);
        chk("release_out_valid", 64'(m_ov), 64'd0);

        // Directed vectors, one at a time, latency measured in edges from acceptance.
        for (int i = 0; i < 10; i++) begin
            m_step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            chk($sformatf("tbl%0d_in_ready", i), 64'(m_ir), 64'd1);
            lat = 0;
            for (int n = 0; n < 20; n++) begin
                m_step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
                lat++;
                if (m_ov) break;
            end
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("tbl%0d_sum", i), 64'(m_sum), 64'(vecs[i].sum));
            chk($sformatf("tbl%0d_cout", i), 64'(m_cout), 64'(vecs[i].cout));
            chk($sformatf("tbl%0d_ovf", i), 64'(m_ovf), 64'(vecs[i].ovf));
        end
        m_drain();

        // Back-to-back stream: one result per clock once the pipe is full.
        for (int i = 0; i < 100; i++) begin
            if (i == 0) m_step(1'b1, 1'b1, 8'h0F, 8'hF1, 1'b0, 1'b0);
            else        m_step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            chk("stream_in_ready", 64'(m_ir), 64'd1);
            if (i >= 4) chk("stream_out_valid", 64'(m_ov), 64'd1);
        end
        m_drain();

        // Backpressure with a full pipe.
        for (int i = 0; i < 6; i++)
            m_step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 5; i++) begin
            m_step(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            chk("stall_in_ready", 64'(m_ir), 64'd0);
            chk("stall_out_valid", 64'(m_ov), 64'd1);
            if (m_q.size() > 0)
                chk("stall_hold", 64'({m_ovf, m_cout, m_sum}), 64'({m_q[0][33], m_q[0][32], m_q[0][7:0]}));
        end
        m_drain();

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++)
            m_step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        @(negedge clk);
        rst_n = 1'b0;
        m_iv  = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(m_ir), 64'd0);
        @(negedge clk);
        #1;
        chk("midrst_out_valid", 64'(m_ov), 64'd0);
        chk("midrst_sum", 64'(m_sum), 64'd0);
        chk("midrst_cout", 64'(m_cout), 64'd0);
        chk("midrst_ovf", 64'(m_ovf), 64'd0);
        m_q.delete();
        rst_n = 1'b1;
        #1;
        chk("midrst_release_in_ready", 64'(m_ir), 64'd1);
        chk("midrst_release_out_valid", 64'(m_ov), 64'd0);
        for (int i = 0; i < 8; i++) begin
            m_step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
            chk("midrst_no_ghost", 64'(m_ov), 64'd0);
        end

        all_done = 4'h0;
        for (int c = 0; c < 20000; c++) begin
            all_done = {g_sweep[3].done, g_sweep[2].done, g_sweep[1].done, g_sweep[0].done};
            if (all_done == 4'hF) break;
            @(negedge clk);
        end
        chk("sweep_done", 64'(all_done), 64'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
